pll_reconfig_ctrl: RTL and testbench

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

---
 rtl/pll_reconfig_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - PLL preset reconfiguration, lock supervision and retry controller
module pll_reconfig_ctrl #(
    parameter int                      NUM_CFG      = 4,
    parameter logic [18*NUM_CFG-1:0]   CFG_TABLE    = {NUM_CFG{6'd4, 6'd11, 6'd4}},
    parameter int                      RESET_CYCLES = 4,
    parameter int                      LOCK_WAIT    = 8,
    parameter int                      TIMEOUT      = 100,
    parameter int                      MAX_RETRY    = 2,
    localparam int                     CW           = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] cfg_sel,
    input  logic          cfg_req,
    output logic          cfg_ack,
    output logic          cfg_nak,
    input  logic          pll_lock,
    output logic          pll_reset,
    output logic [5:0]    pll_idsel,
    output logic [5:0]    pll_fbdsel,
    output logic [5:0]    pll_odsel,
    output logic [CW-1:0] active_cfg,
    output logic          clk_ready,
    output logic          busy,
    output logic          error,
    output logic [7:0]    relock_count
);

    // One counter serves both the reset hold and the stable-lock qualification.
    localparam int CMAX  = (RESET_CYCLES > LOCK_WAIT) ? RESET_CYCLES : LOCK_WAIT;
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW:0] NUM_CFG_W = (CW + 1)'(NUM_CFG);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_LOCKED,
        S_FAULT
    } state_e;

    state_e            state_q, state_d;
    logic              sync1_q, lock_s_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [7:0]        relock_q, relock_d;
    logic [17:0]       sel_q, sel_d;
    logic [CW-1:0]     active_q, active_d;
    logic              ack_q, ack_d, nak_q, nak_d;
    logic              pll_reset_q, pll_reset_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic              sel_ok, accept;
    logic [17:0]       entry;

    assign sel_ok = ({1'b0, cfg_sel} < NUM_CFG_W);
    assign accept = cfg_req && sel_ok && ((state_q == S_LOCKED) || (state_q == S_FAULT));
    assign entry  = CFG_TABLE[18*int'(cfg_sel) +: 18];

    // Two-flop synchroniser for the asynchronous PLL lock indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    // State register plus all counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            timer_q     <= '0;
            retry_q     <= '0;
            relock_q    <= '0;
            sel_q       <= CFG_TABLE[17:0];
            active_q    <= '0;
            ack_q       <= 1'b0;
            nak_q       <= 1'b0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            relock_q    <= relock_d;
            sel_q       <= sel_d;
            active_q    <= active_d;
            ack_q       <= ack_d;
            nak_q       <= nak_d;
            pll_reset_q <= pll_reset_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    // Next-state and datapath: sequencing, retries, request arbitration
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        sel_d    = sel_q;
        active_d = active_q;
        ack_d    = 1'b0;
        nak_d    = 1'b0;
        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    timer_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_RESET_PLL;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_FAULT;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STABLE: begin
                // A dropout returns to WAIT_LOCK but keeps the attempt timer running
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == CNT_W'(LOCK_WAIT - 1)) begin
                    state_d = S_LOCKED;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOCKED: begin
                if (!lock_s_q) begin
                    if (relock_q != 8'hFF) relock_d = relock_q + 1'b1;
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            S_FAULT: ;
            default: state_d = S_RESET_PLL;
        endcase
        // An accepted request overrides everything above, including a coincident lock loss
        if (accept) begin
            state_d  = S_RESET_PLL;
            cnt_d    = '0;
            retry_d  = '0;
            relock_d = relock_q;
            sel_d    = entry;
            active_d = cfg_sel;
            ack_d    = 1'b1;
        end else if (cfg_req) begin
            nak_d = 1'b1;
        end
    end

    // Output decode from the next state so every output is registered
    always_comb begin
        pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        ready_d     = (state_d == S_LOCKED);
        busy_d      = (state_d == S_RESET_PLL) || (state_d == S_WAIT_LOCK) || (state_d == S_STABLE);
        error_d     = (state_d == S_FAULT);
    end

    assign cfg_ack      = ack_q;
    assign cfg_nak      = nak_q;
    assign pll_reset    = pll_reset_q;
    assign pll_idsel    = sel_q[17:12];
    assign pll_fbdsel   = sel_q[11:6];
    assign pll_odsel    = sel_q[5:0];
    assign active_cfg   = active_q;
    assign clk_ready    = ready_q;
    assign busy         = busy_q;
    assign error        = error_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - directed-vector bench for pll_reconfig_ctrl
module tb_pll_reconfig_ctrl;

    localparam logic [17:0] E0 = {6'd4, 6'd11, 6'd4};
    localparam logic [17:0] E1 = {6'd1, 6'd20, 6'd2};
    localparam logic [17:0] E2 = {6'd2, 6'd33, 6'd3};
    localparam logic [17:0] E3 = {6'd5, 6'd40, 6'd1};
    localparam logic [17:0] E4 = {6'd3, 6'd7,  6'd6};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cfg_sel;
    logic       cfg_req;
    logic       cfg_ack, cfg_nak;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [2:0] active_cfg;
    logic       clk_ready, busy, error;
    logic [7:0] relock_count;

    int n_vec = 0;
    int n_err = 0;

    pll_reconfig_ctrl #(
        .NUM_CFG      (5),
        .CFG_TABLE    ({E4, E3, E2, E1, E0}),
        .RESET_CYCLES (4),
        .LOCK_WAIT    (8),
        .TIMEOUT      (100),
        .MAX_RETRY    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_sel      (cfg_sel),
        .cfg_req      (cfg_req),
        .cfg_ack      (cfg_ack),
        .cfg_nak      (cfg_nak),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .pll_idsel    (pll_idsel),
        .pll_fbdsel   (pll_fbdsel),
        .pll_odsel    (pll_odsel),
        .active_cfg   (active_cfg),
        .clk_ready    (clk_ready),
        .busy         (busy),
        .error        (error),
        .relock_count (relock_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive pll_reset-high samples starting at the current one
    task automatic count_reset(output int n);
        n = 0;
        while (pll_reset && n < 20) begin
            n++;
            tick();
        end
    endtask

    // Cycles until clk_ready is seen high, bounded
    task automatic wait_ready(output int n);
        n = 0;
        while (!clk_ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic lose_lock();
        int n;
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        repeat (2) tick();
        count_reset(n);
        wait_ready(n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rose, n_rst, cyc;
        rst_n = 1'b0; pll_lock = 1'b0; cfg_req = 1'b0; cfg_sel = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pll_reset", pll_reset, 1);
        check_eq("rst_ready", clk_ready, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_error", error, 0);
        check_eq("rst_acknak", {cfg_ack, cfg_nak}, 0);
        check_eq("rst_active", active_cfg, 0);
        check_eq("rst_sels", {pll_idsel, pll_fbdsel, pll_odsel}, E0);
        check_eq("rst_relock", relock_count, 0);

        // Power-up: lock appears at cycle 10, ready at cycle 21
        rst_n = 1'b1;
        count_reset(n);
        check_eq("pu_reset_len", n, 4);
        repeat (6) tick();
        pll_lock = 1'b1;
        wait_ready(n);
        check_eq("pu_ready_lat", n, 11);
        check_eq("pu_active", active_cfg, 0);
        check_eq("pu_relock", relock_count, 0);

        // Reconfigure to preset 2
        cfg_sel = 3'd2; cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        check_eq("cfg2_ack", cfg_ack, 1);
        check_eq("cfg2_ready", clk_ready, 0);
        check_eq("cfg2_sels", {pll_idsel, pll_fbdsel, pll_odsel}, E2);
        check_eq("cfg2_active", active_cfg, 2);
        count_reset(n);
        check_eq("cfg2_reset_len", n, 4);
        wait_ready(n);
        check_eq("cfg2_ready_lat", n, 9);

        // Out-of-range request while locked
        cfg_sel = 3'd5; cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        check_eq("oor_nak", {cfg_nak, cfg_ack}, 2'b10);
        check_eq("oor_ready", clk_ready, 1);
        check_eq("oor_active", active_cfg, 2);
        tick();
        check_eq("oor_nak_pulse", cfg_nak, 0);

        // One-cycle lock dropout
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        check_eq("drop_ready_b2", clk_ready, 1);
        tick();
        check_eq("drop_ready_b3", clk_ready, 0);
        check_eq("drop_relock", relock_count, 1);
        check_eq("drop_sels", {pll_idsel, pll_fbdsel, pll_odsel}, E2);
        count_reset(n);
        check_eq("drop_reset_len", n, 4);
        check_eq("wait_busy", busy, 1);
        cfg_sel = 3'd1; cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        check_eq("busy_nak", {cfg_nak, cfg_ack}, 2'b10);
        check_eq("busy_active", active_cfg, 2);
        wait_ready(n);
        check_eq("drop_ready_lat", n, 8);

        // Request coinciding with lock loss: request wins
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        cfg_sel = 3'd1; cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        check_eq("coin_ack", cfg_ack, 1);
        check_eq("coin_relock", relock_count, 1);
        check_eq("coin_sels", {pll_idsel, pll_fbdsel, pll_odsel}, E1);
        count_reset(n);
        wait_ready(n);
        check_eq("coin_ready_lat", n, 9);

        // Relock counter saturation
        for (int i = 0; i < 253; i++) lose_lock();
        check_eq("relock_254", relock_count, 254);
        lose_lock();
        check_eq("relock_255", relock_count, 255);
        lose_lock();
        check_eq("relock_sat", relock_count, 255);
        check_eq("sat_ready", clk_ready, 1);

        // Lock glitches: 7 high / 1 low never qualifies
        pll_lock = 1'b0;
        repeat (3) tick();
        check_eq("gl_ready_drop", clk_ready, 0);
        rose = 0;
        for (int p = 0; p < 5; p++) begin
            pll_lock = 1'b1;
            repeat (7) begin tick(); rose |= int'(clk_ready); end
            pll_lock = 1'b0;
            tick(); rose |= int'(clk_ready);
        end
        check_eq("gl_no_ready", rose, 0);
        pll_lock = 1'b1;
        wait_ready(n);
        check_eq("gl_ready_after", clk_ready, 1);

        // Asynchronous reset in the middle of STABLE
        pll_lock = 1'b0;
        repeat (3) tick();
        pll_lock = 1'b1;
        count_reset(n);
        repeat (2) tick();
        check_eq("st_in_stable", {busy, pll_reset, clk_ready}, 3'b100);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_pll_reset", pll_reset, 1);
        check_eq("ar_busy", busy, 1);
        check_eq("ar_relock", relock_count, 0);
        check_eq("ar_active", active_cfg, 0);
        check_eq("ar_sels", {pll_idsel, pll_fbdsel, pll_odsel}, E0);

        // Lock never arrives: three attempts then FAULT
        pll_lock = 1'b0;
        tick();
        rst_n = 1'b1;
        n_rst = 0; cyc = 0;
        while (!error && cyc < 400) begin
            n_rst += int'(pll_reset);
            tick();
            cyc++;
        end
        check_eq("flt_cycle", cyc, 312);
        check_eq("flt_reset_cycles", n_rst, 12);
        check_eq("flt_flags", {error, busy, pll_reset, clk_ready}, 4'b1010);
        repeat (5) tick();
        check_eq("flt_hold", error, 1);
        cfg_sel = 3'd7; cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        check_eq("flt_nak", {cfg_nak, error}, 2'b11);
        cfg_sel = 3'd3; cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        pll_lock = 1'b1;
        check_eq("flt_ack", {cfg_ack, error, busy}, 3'b101);
        check_eq("flt_active", active_cfg, 3);
        check_eq("flt_sels", {pll_idsel, pll_fbdsel, pll_odsel}, E3);
        count_reset(n);
        check_eq("flt_reset_len", n, 4);
        wait_ready(n);
        check_eq("flt_ready_lat", n, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
